tx_arbiter: RTL and testbench

//  Schedules and shares the Econet transmit datapath between two frame sources: host (SPI-fed) and

---
 rtl/tx_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares the Econet TX datapath between the host (SPI) frame source
// and the local ACK generator. It grants one source per frame, pulses tx_go,
// feeds words on a strobe/request interface, inserts a flag-fill gap between
// frames, and aborts a frame on datapath underflow or a stalled source.
// Optional feature macro: TX_ARB_STATS_EN adds the frames_ok/frames_abort counters.
//
// Handshake: a source word moves when <src>_valid and <src>_ready are both high
// in the same cycle. Ready is only raised for the granted source, in FEED, while
// the datapath requests a word and no underflow is reported.
module tx_arbiter #(
    parameter int GAP_CYCLES   = 16,
    parameter int WORD_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        host_req,
    input  logic [15:0] host_data,
    input  logic        host_valid,
    output logic        host_ready,
    output logic        host_grant,
    input  logic        ack_req,
    input  logic [15:0] ack_data,
    input  logic        ack_valid,
    output logic        ack_ready,
    output logic        ack_grant,
    output logic [15:0] tx_data,
    output logic        tx_strobe,
    input  logic        tx_request,
    output logic        tx_go,
    input  logic        tx_underflow,
    output logic        flag_fill,
    output logic        frame_done,
    output logic        frame_abort
`ifdef TX_ARB_STATS_EN
    ,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_abort
`endif
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(WORD_TIMEOUT - 1);
    localparam logic [15:0]      ABORT_WORD   = 16'h8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_STROBE,
        S_ABORT,
        S_GAP
    } state_t;

    state_t           r_state;
    logic             r_host_grant;
    logic             r_ack_grant;
    logic             r_last_ack;     // 1: most recent grant went to ACK
    logic             r_tx_go;
    logic             r_tx_strobe;
    logic [15:0]      r_tx_data;
    logic             r_flag_fill;
    logic             r_frame_done;
    logic             r_frame_abort;
    logic             r_eop;          // eop bit of the word currently being strobed
    logic [CNT_W-1:0] r_timeout_cnt;
    logic [GAP_W-1:0] r_gap_cnt;

    logic             w_host_wins;
    logic             w_valid;
    logic [15:0]      w_word;
    logic             w_accept;

    // ACK is favoured, but host gets the next frame after an ACK frame.
    assign w_host_wins = host_req && (!ack_req || r_last_ack);
    // Grants are mutually exclusive, so muxing on host grant selects the owner.
    assign w_valid     = r_host_grant ? host_valid : ack_valid;
    assign w_word      = r_host_grant ? host_data  : ack_data;
    // Underflow wins over a coincident accept: the word stays in the source.
    assign w_accept    = (r_state == S_FEED) && tx_request && w_valid && !tx_underflow;
    assign host_ready  = w_accept && r_host_grant;
    assign ack_ready   = w_accept && r_ack_grant;

    assign host_grant  = r_host_grant;
    assign ack_grant   = r_ack_grant;
    assign tx_data     = r_tx_data;
    assign tx_strobe   = r_tx_strobe;
    assign tx_go       = r_tx_go;
    assign flag_fill   = r_flag_fill;
    assign frame_done  = r_frame_done;
    assign frame_abort = r_frame_abort;

    // Frame scheduler FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_host_grant  <= 1'b0;
            r_ack_grant   <= 1'b0;
            r_last_ack    <= 1'b0;
            r_tx_go       <= 1'b0;
            r_tx_strobe   <= 1'b0;
            r_tx_data     <= 16'h0000;
            r_flag_fill   <= 1'b1;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
            r_eop         <= 1'b0;
            r_timeout_cnt <= '0;
            r_gap_cnt     <= '0;
        end else begin
            r_tx_go       <= 1'b0;
            r_tx_strobe   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (host_req || ack_req) begin
                        r_host_grant  <= w_host_wins;
                        r_ack_grant   <= !w_host_wins;
                        r_last_ack    <= !w_host_wins;
                        r_tx_go       <= 1'b1;
                        r_flag_fill   <= 1'b0;
                        r_timeout_cnt <= '0;
                        r_state       <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_FEED;
                end
                S_FEED: begin
                    if (tx_underflow) begin
                        r_state <= S_ABORT;
                    end else if (w_accept) begin
                        r_tx_data     <= w_word;
                        r_tx_strobe   <= 1'b1;
                        r_eop         <= w_word[15];
                        r_timeout_cnt <= '0;
                        r_state       <= S_STROBE;
                    end else if (tx_request) begin
                        // Datapath is waiting and the owner has nothing to give.
                        if (r_timeout_cnt == TIMEOUT_LAST) begin
                            r_state <= S_ABORT;
                        end else begin
                            r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
                        end
                    end
                end
                S_STROBE: begin
                    // tx_request is stale here; the datapath has not seen the strobe yet.
                    if (tx_underflow) begin
                        r_state <= S_ABORT;
                    end else if (r_eop) begin
                        r_frame_done <= 1'b1;
                        r_host_grant <= 1'b0;
                        r_ack_grant  <= 1'b0;
                        r_flag_fill  <= 1'b1;
                        r_gap_cnt    <= '0;
                        r_state      <= S_GAP;
                    end else begin
                        r_state <= S_FEED;
                    end
                end
                S_ABORT: begin
                    // Close the frame on the line with an empty eop word.
                    r_tx_data     <= ABORT_WORD;
                    r_tx_strobe   <= 1'b1;
                    r_frame_abort <= 1'b1;
                    r_host_grant  <= 1'b0;
                    r_ack_grant   <= 1'b0;
                    r_flag_fill   <= 1'b1;
                    r_gap_cnt     <= '0;
                    r_state       <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TX_ARB_STATS_EN
    logic [15:0] r_frames_ok;
    logic [15:0] r_frames_abort;

    assign frames_ok    = r_frames_ok;
    assign frames_abort = r_frames_abort;

    // Saturating completion/abort counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frames_ok    <= 16'h0000;
            r_frames_abort <= 16'h0000;
        end else begin
            if (r_frame_done && (r_frames_ok != 16'hFFFF)) begin
                r_frames_ok <= r_frames_ok + 16'd1;
            end
            if (r_frame_abort && (r_frames_abort != 16'hFFFF)) begin
                r_frames_abort <= r_frames_abort + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: arbitration order, word feed, timeout and
// underflow aborts, asynchronous reset, and the optional statistics counters.
module tb_tx_arbiter;

    localparam int GAP = 16;
    localparam int TMO = 255;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        host_req, host_valid, host_ready, host_grant;
    logic [15:0] host_data;
    logic        ack_req, ack_valid, ack_ready, ack_grant;
    logic [15:0] ack_data;
    logic [15:0] tx_data;
    logic        tx_strobe, tx_request, tx_go, tx_underflow;
    logic        flag_fill, frame_done, frame_abort;
`ifdef TX_ARB_STATS_EN
    logic [15:0] frames_ok, frames_abort;
`endif

    tx_arbiter #(.GAP_CYCLES(GAP), .WORD_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .host_req(host_req), .host_data(host_data), .host_valid(host_valid),
        .host_ready(host_ready), .host_grant(host_grant),
        .ack_req(ack_req), .ack_data(ack_data), .ack_valid(ack_valid),
        .ack_ready(ack_ready), .ack_grant(ack_grant),
        .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_request(tx_request),
        .tx_go(tx_go), .tx_underflow(tx_underflow), .flag_fill(flag_fill),
        .frame_done(frame_done), .frame_abort(frame_abort)
`ifdef TX_ARB_STATS_EN
        , .frames_ok(frames_ok), .frames_abort(frames_abort)
`endif
    );

    // ---------------- scoreboard state ----------------
    int          n_total = 0;
    int          n_bad = 0;
    logic [15:0] host_q[$];
    logic [15:0] ack_q[$];
    logic [15:0] strobe_q[$];
    logic [31:0] grant_q[$];   // 1 = ACK frame, 0 = host frame
    logic [31:0] exp_q[$];
    bit          host_force = 1'b0;
    bit          host_acc = 1'b0, ack_acc = 1'b0;
    int          req_dly = 0;
    int          n_go = 0, n_strobe = 0, n_wide = 0, n_done = 0, n_abort = 0;
    int          n_host_rdy = 0, n_ack_rdy = 0, n_both_grant = 0, n_both_end = 0;
    int          ff_run = 0, last_gap = 0;
    logic        prev_strobe = 1'b0, prev_ack_g = 1'b0, prev_host_g = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver: sources and datapath request echo ----------------
    always @(posedge clk) begin
        #1;
        if (host_acc && host_q.size() > 0) host_q.delete(0);
        if (ack_acc && ack_q.size() > 0) ack_q.delete(0);
        host_req   = (host_q.size() > 0) || host_force;
        host_valid = host_q.size() > 0;
        host_data  = host_valid ? host_q[0] : 16'h0000;
        ack_req    = ack_q.size() > 0;
        ack_valid  = ack_q.size() > 0;
        ack_data   = ack_valid ? ack_q[0] : 16'h0000;
        if (tx_strobe) begin
            tx_request = 1'b0;
            req_dly    = 2;
        end else if (req_dly > 0) begin
            req_dly--;
            if (req_dly == 0) tx_request = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        host_acc = host_ready;
        ack_acc  = ack_ready;
        if (host_ready) n_host_rdy++;
        if (ack_ready) n_ack_rdy++;
        if (tx_go) begin
            n_go++;
            last_gap = ff_run;
        end
        if (tx_strobe) begin
            n_strobe++;
            strobe_q.push_back(tx_data);
            if (prev_strobe) n_wide++;
        end
        prev_strobe = tx_strobe;
        if (frame_done) n_done++;
        if (frame_abort) n_abort++;
        if (frame_done && frame_abort) n_both_end++;
        if (host_grant && ack_grant) n_both_grant++;
        if (ack_grant && !prev_ack_g) grant_q.push_back(32'd1);
        if (host_grant && !prev_host_g) grant_q.push_back(32'd0);
        prev_ack_g  = ack_grant;
        prev_host_g = host_grant;
        if (frame_done || frame_abort) ff_run = 1;
        else if (flag_fill) ff_run++;
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int n, input int limit, input string tag);
        int base;
        int k;
        base = n_done + n_abort;
        k = 0;
        while ((n_done + n_abort) < base + n && k < limit) begin
            tick(1);
            k++;
        end
        chk({tag, "_frame_end_seen"}, 32'((n_done + n_abort) >= base + n), 32'd1);
    endtask

    task automatic wait_go(input int limit, input string tag);
        int k;
        k = 0;
        while (tx_go !== 1'b1 && k < limit) begin
            tick(1);
            k++;
        end
        chk({tag, "_go_seen"}, 32'(tx_go), 32'd1);
    endtask

    // One ACK frame aborted by an underflow coinciding with the first accept.
    task automatic uf_frame(input string tag);
        @(posedge clk); #1;
        ack_q.push_back(16'h4077);
        ack_q.push_back(16'hC088);
        wait_go(40, tag);
        @(posedge clk); #1;          // first FEED cycle: request and valid are high
        tx_underflow = 1'b1;
        @(negedge clk); #1;
        chk({tag, "_no_ready"}, 32'(ack_ready), 32'd0);
        @(posedge clk); #1;
        tx_underflow = 1'b0;
        wait_frames(1, 40, tag);
        ack_q.delete();               // source flushes on falling grant
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0, a0, s0, g0, r0, h0;
        int cnt;
        host_req = 1'b0; host_valid = 1'b0; host_data = 16'h0;
        ack_req = 1'b0; ack_valid = 1'b0; ack_data = 16'h0;
        tx_request = 1'b1; tx_underflow = 1'b0;

        // reset state
        tick(3);
        chk("rst_host_grant", 32'(host_grant), 32'd0);
        chk("rst_ack_grant", 32'(ack_grant), 32'd0);
        chk("rst_strobe", 32'(tx_strobe), 32'd0);
        chk("rst_go", 32'(tx_go), 32'd0);
        chk("rst_flag_fill", 32'(flag_fill), 32'd1);
        chk("rst_done_abort", 32'({frame_done, frame_abort}), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // simultaneous requests: ACK, host, ACK, host, ACK(zero-length), host
        d0 = n_done; a0 = n_abort; s0 = n_strobe;
        grant_q.delete();
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #1;
            ack_q.push_back(p == 2 ? 16'h8000 : 16'hC0AA);
            host_q.push_back(16'h4055);
            host_q.push_back(16'hC066);
            wait_frames(2, 300, "pair");
            if (p == 0) chk("pair_gap_len", 32'(last_gap), 32'(GAP + 1));
            tick(GAP + 4);
        end
        exp_q = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
        chk("pair_grant_cnt", 32'(grant_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_q.size()) chk("pair_grant_order", grant_q[i], exp_q[i]);
        end
        chk("pair_done_cnt", 32'(n_done - d0), 32'd6);
        chk("pair_abort_cnt", 32'(n_abort - a0), 32'd0);
        chk("pair_strobe_cnt", 32'(n_strobe - s0), 32'd9);
        chk("pair_zero_len_word", 32'(strobe_q[strobe_q.size() - 3]), 32'h8000);

        // ACK only, three words
        d0 = n_done; a0 = n_abort; s0 = n_strobe; g0 = n_go;
        r0 = n_ack_rdy; h0 = n_host_rdy;
        strobe_q.delete();
        @(posedge clk); #1;
        ack_q.push_back(16'h4011);
        ack_q.push_back(16'h4022);
        ack_q.push_back(16'hC033);
        wait_frames(1, 200, "ack3");
        chk("ack3_grant_dropped", 32'(ack_grant), 32'd0);
        cnt = 0;
        for (int i = 0; i < GAP; i++) begin
            if (flag_fill === 1'b1) cnt++;
            tick(1);
        end
        chk("ack3_gap_flag", 32'(cnt), 32'(GAP));
        chk("ack3_go_cnt", 32'(n_go - g0), 32'd1);
        chk("ack3_strobe_cnt", 32'(n_strobe - s0), 32'd3);
        chk("ack3_done_cnt", 32'(n_done - d0), 32'd1);
        chk("ack3_abort_cnt", 32'(n_abort - a0), 32'd0);
        chk("ack3_ready_cnt", 32'(n_ack_rdy - r0), 32'd3);
        chk("ack3_host_ready", 32'(n_host_rdy - h0), 32'd0);
        exp_q = '{32'h4011, 32'h4022, 32'hC033};
        for (int i = 0; i < 3; i++) begin
            if (i < strobe_q.size()) chk("ack3_word", 32'(strobe_q[i]), exp_q[i]);
        end
        tick(4);

        // host stall timeout
        d0 = n_done;
        @(posedge clk); #1;
        host_force = 1'b1;
        wait_go(40, "tmo");
        chk("tmo_host_granted", 32'(host_grant), 32'd1);
        cnt = 0;
        while (frame_abort !== 1'b1 && cnt < 400) begin
            tick(1);
            cnt++;
        end
        host_force = 1'b0;
        chk("tmo_latency", 32'(cnt), 32'(TMO + 2));
        chk("tmo_strobe", 32'(tx_strobe), 32'd1);
        chk("tmo_word", 32'(tx_data), 32'h8000);
        chk("tmo_grant_drop", 32'(host_grant), 32'd0);
        chk("tmo_no_done", 32'(n_done - d0), 32'd0);
        tick(GAP + 4);

        // underflow coincident with accept
        d0 = n_done; a0 = n_abort; r0 = n_ack_rdy;
        uf_frame("uf");
        chk("uf_abort_cnt", 32'(n_abort - a0), 32'd1);
        chk("uf_no_done", 32'(n_done - d0), 32'd0);
        chk("uf_ready_cnt", 32'(n_ack_rdy - r0), 32'd0);
        chk("uf_word", 32'(strobe_q[strobe_q.size() - 1]), 32'h8000);
        tick(GAP + 4);

        // asynchronous reset mid-FEED
        @(posedge clk); #1;
        host_force = 1'b1;
        wait_go(40, "arst");
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_host_grant", 32'(host_grant), 32'd0);
        chk("arst_ack_grant", 32'(ack_grant), 32'd0);
        chk("arst_strobe", 32'(tx_strobe), 32'd0);
        chk("arst_flag_fill", 32'(flag_fill), 32'd1);
        host_force = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        chk("arst_idle_flag", 32'(flag_fill), 32'd1);
        chk("arst_idle_grant", 32'({host_grant, ack_grant}), 32'd0);
        chk("arst_idle_go", 32'(tx_go), 32'd0);

`ifdef TX_ARB_STATS_EN
        // statistics: two good frames then one aborted frame
        @(posedge clk); #1;
        ack_q.push_back(16'hC001);
        ack_q.push_back(16'hC002);
        wait_frames(2, 200, "stat");
        tick(GAP + 4);
        uf_frame("stat_uf");
        tick(3);
        chk("stat_frames_ok", 32'(frames_ok), 32'd2);
        chk("stat_frames_abort", 32'(frames_abort), 32'd1);
`endif

        chk("global_wide_strobe", 32'(n_wide), 32'd0);
        chk("global_both_grant", 32'(n_both_grant), 32'd0);
        chk("global_done_and_abort", 32'(n_both_end), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
